// File: rtl/stage_mem_pkg.sv
// Shared widths, control encodings and the memory-stage FSM state type.
// wb_ctl selects the writeback source; byt_typ selects access width and signedness.
package stage_mem_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int MEM_ADDR_WIDTH = 32;
    localparam int WORD_WIDTH     = 32;

    localparam logic [1:0] WB_RSLT = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_IMM  = 2'b10;
    localparam logic [1:0] WB_ZERO = 2'b11;

    localparam logic [2:0] BT_B  = 3'b000;
    localparam logic [2:0] BT_H  = 3'b001;
    localparam logic [2:0] BT_W  = 3'b010;
    localparam logic [2:0] BT_BU = 3'b100;
    localparam logic [2:0] BT_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Stores only know SB/SH/SW, so unsigned codes fall back to word width for them.
    function automatic logic access_misaligned(input logic [2:0] byt_typ,
                                               input logic       is_store,
                                               input logic [1:0] addr_lo);
        logic is_byte;
        logic is_half;
        is_byte = (byt_typ == BT_B) || (!is_store && byt_typ == BT_BU);
        is_half = (byt_typ == BT_H) || (!is_store && byt_typ == BT_HU);
        if (is_byte)      return 1'b0;
        else if (is_half) return addr_lo[0];
        else              return |addr_lo;
    endfunction

endpackage

// File: rtl/stage_mem_align.sv
// Combinational lane steering: store byte enables and replicated write data, load extraction.
// Store codes beyond SB/SH and load codes beyond LB/LH/LBU/LHU behave as full words.
module load_store_align
    import stage_mem_pkg::*;
(
    input  logic [2:0]            byt_typ,
    input  logic [1:0]            addr_lo,
    input  logic [WORD_WIDTH-1:0] rs2,
    input  logic [WORD_WIDTH-1:0] rdata,
    output logic [3:0]            be,
    output logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be    = 4'b1111;
        wdata = rs2;
        case (byt_typ)
            BT_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{rs2[7:0]}};
            end
            BT_H: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rs2[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = rs2;
            end
        endcase
    end

    always_comb begin
        ld_byte = rdata[{addr_lo, 3'b000} +: 8];
        ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (byt_typ)
            BT_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            BT_BU:   ld_data = {24'h0, ld_byte};
            BT_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            BT_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// Pipeline memory stage: registers EX results, runs one data-memory access, feeds WB and forwarding.
// One cycle EX->WB; every cycle without dmem_ack while requesting holds the stage via stall_out.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int reg_addr_width = REG_ADDR_WIDTH,
    parameter int ins_addr_width = MEM_ADDR_WIDTH,
    parameter int word_width     = WORD_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ins_addr_width-1:0] tgt_addr_in,
    input  logic [word_width-1:0]     rslt_in,
    input  logic [word_width-1:0]     rs2_val_in,
    input  logic [word_width-1:0]     imm_ext_in,
    input  logic [reg_addr_width-1:0] rd_addr_in,
    input  logic [2:0]                byt_typ_in,
    input  logic [1:0]                wb_ctl_in,
    input  logic                      jmp_ctl_in,
    input  logic                      rd_wen_in,
    input  logic                      bch_ctl_in,
    input  logic                      mem_ctl_in,
    output logic                      dmem_req,
    output logic                      dmem_wen,
    output logic [word_width-1:0]     dmem_addr,
    output logic [word_width-1:0]     dmem_wdata,
    output logic [3:0]                dmem_be,
    input  logic                      dmem_ack,
    input  logic [word_width-1:0]     dmem_rdata,
    output logic                      mem_wen_out,
    output logic [reg_addr_width-1:0] mem_rd_out,
    output logic [word_width-1:0]     mem_d_out,
    output logic                      rd_wen_out,
    output logic [reg_addr_width-1:0] rd_addr_out,
    output logic [1:0]                wb_ctl_out,
    output logic [word_width-1:0]     wb_d_out,
    output logic                      stall_out,
    output logic                      pc_sel_out,
    output logic [ins_addr_width-1:0] tgt_addr_out,
    output logic                      misalign_out
);

    logic [ins_addr_width-1:0] tgt_addr_q, tgt_addr_d;
    logic [word_width-1:0]     rslt_q, rslt_d;
    logic [word_width-1:0]     rs2_val_q, rs2_val_d;
    logic [word_width-1:0]     imm_ext_q, imm_ext_d;
    logic [reg_addr_width-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]                byt_typ_q, byt_typ_d;
    logic [1:0]                wb_ctl_q, wb_ctl_d;
    logic                      jmp_ctl_q, jmp_ctl_d;
    logic                      rd_wen_q, rd_wen_d;
    logic                      bch_ctl_q, bch_ctl_d;
    logic                      mem_ctl_q, mem_ctl_d;
    mem_state_e                state_q, state_d;

    logic                  is_store, is_load, misaligned, access_ok;
    logic [3:0]            align_be;
    logic [word_width-1:0] align_wdata, ld_data;

    always_comb begin
        tgt_addr_d = tgt_addr_q;
        rslt_d     = rslt_q;
        rs2_val_d  = rs2_val_q;
        imm_ext_d  = imm_ext_q;
        rd_addr_d  = rd_addr_q;
        byt_typ_d  = byt_typ_q;
        wb_ctl_d   = wb_ctl_q;
        jmp_ctl_d  = jmp_ctl_q;
        rd_wen_d   = rd_wen_q;
        bch_ctl_d  = bch_ctl_q;
        mem_ctl_d  = mem_ctl_q;
        if (!stall_out) begin
            tgt_addr_d = tgt_addr_in;
            rslt_d     = rslt_in;
            rs2_val_d  = rs2_val_in;
            imm_ext_d  = imm_ext_in;
            rd_addr_d  = rd_addr_in;
            byt_typ_d  = byt_typ_in;
            wb_ctl_d   = wb_ctl_in;
            jmp_ctl_d  = jmp_ctl_in;
            rd_wen_d   = rd_wen_in;
            bch_ctl_d  = bch_ctl_in;
            mem_ctl_d  = mem_ctl_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_addr_q <= '0;
            rslt_q     <= '0;
            rs2_val_q  <= '0;
            imm_ext_q  <= '0;
            rd_addr_q  <= '0;
            byt_typ_q  <= '0;
            wb_ctl_q   <= '0;
            jmp_ctl_q  <= 1'b0;
            rd_wen_q   <= 1'b0;
            bch_ctl_q  <= 1'b0;
            mem_ctl_q  <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            tgt_addr_q <= tgt_addr_d;
            rslt_q     <= rslt_d;
            rs2_val_q  <= rs2_val_d;
            imm_ext_q  <= imm_ext_d;
            rd_addr_q  <= rd_addr_d;
            byt_typ_q  <= byt_typ_d;
            wb_ctl_q   <= wb_ctl_d;
            jmp_ctl_q  <= jmp_ctl_d;
            rd_wen_q   <= rd_wen_d;
            bch_ctl_q  <= bch_ctl_d;
            mem_ctl_q  <= mem_ctl_d;
            state_q    <= state_d;
        end
    end

    load_store_align u_align (
        .byt_typ (byt_typ_q),
        .addr_lo (rslt_q[1:0]),
        .rs2     (rs2_val_q),
        .rdata   (dmem_rdata),
        .be      (align_be),
        .wdata   (align_wdata),
        .ld_data (ld_data)
    );

    always_comb begin
        is_store   = mem_ctl_q;
        is_load    = (wb_ctl_q == WB_LOAD) && rd_wen_q;
        misaligned = (is_store || is_load) && access_misaligned(byt_typ_q, is_store, rslt_q[1:0]);
        access_ok  = (is_store || is_load) && !misaligned;

        // The input register is frozen in WAIT, so access_ok already holds there.
        dmem_req   = access_ok || (state_q == ST_WAIT);
        dmem_wen   = dmem_req && is_store;
        dmem_addr  = rslt_q;
        dmem_wdata = align_wdata;
        dmem_be    = (dmem_req && is_store) ? align_be : 4'b0000;
        stall_out  = dmem_req && !dmem_ack;

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (dmem_req && !dmem_ack) state_d = ST_WAIT;
            ST_WAIT: if (dmem_ack)              state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase

        misalign_out = misaligned;
        rd_wen_out   = rd_wen_q && !misaligned;
        rd_addr_out  = rd_addr_q;
        wb_ctl_out   = wb_ctl_q;
        case (wb_ctl_q)
            WB_RSLT: wb_d_out = rslt_q;
            WB_LOAD: wb_d_out = ld_data;
            WB_IMM:  wb_d_out = imm_ext_q;
            default: wb_d_out = '0;
        endcase

        mem_d_out    = wb_d_out;
        mem_wen_out  = rd_wen_out && !stall_out;
        mem_rd_out   = rd_addr_q;
        pc_sel_out   = (jmp_ctl_q || (bch_ctl_q && rslt_q[0])) && !stall_out;
        tgt_addr_out = stall_out ? '0 : tgt_addr_q;
    end

endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_MEM

Interface
REQ-001 Parameters SHALL be: reg_addr_width, default `REG_ADDR_WIDTH, register index width; ins_addr_width, default `MEM_ADDR_WIDTH, instruction address width; word_width, default `WORD_WIDTH, datapath width (32).
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 EX-side inputs SHALL be: tgt_addr_in (ins_addr_width), rslt_in, rs2_val_in, imm_ext_in (word_width), rd_addr_in (reg_addr_width), byt_typ_in (3), wb_ctl_in (2), jmp_ctl_in, rd_wen_in, bch_ctl_in, mem_ctl_in (1 each).
REQ-005 Data-memory outputs SHALL be: dmem_req (1), dmem_wen (1), dmem_addr (word_width), dmem_wdata (word_width), dmem_be (4). Data-memory inputs SHALL be: dmem_ack (1), dmem_rdata (word_width).
REQ-006 Forwarding outputs SHALL be: mem_wen_out (1), mem_rd_out (reg_addr_width), mem_d_out (word_width).
REQ-007 WB-side outputs SHALL be: rd_wen_out (1), rd_addr_out, wb_ctl_out (2), wb_d_out (word_width).
REQ-008 Control outputs SHALL be: stall_out (1), pc_sel_out (1), tgt_addr_out (ins_addr_width), misalign_out (1).

Function
REQ-009 An input register SHALL capture all EX-side inputs on posedge clk when stall_out=0 and SHALL hold them when stall_out=1.
REQ-010 Decode SHALL be: store = mem_ctl; load = (wb_ctl==2'b01) & rd_wen; dmem_addr = registered rslt.
REQ-011 Misalignment SHALL be flagged for halfword accesses when addr[0]=1 and for word accesses when addr[1:0]!=0; misalign_out=1 while the flagged instruction is held.
REQ-012 A flagged access SHALL issue no request and SHALL suppress rd_wen_out.
REQ-013 Store lanes SHALL be: byt_typ 000 = SB, dmem_be = 1<<addr[1:0], wdata = rs2[7:0] replicated x4; 001 = SH, dmem_be = 0011 or 1100 by addr[1], wdata = rs2[15:0] replicated x2; 010 = SW, dmem_be = 1111.
REQ-014 For loads, dmem_be SHALL = 0000.
REQ-015 Load extraction SHALL use addr[1:0] lane select: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend.
REQ-016 Any other byt_typ SHALL be treated as LW/SW.
REQ-017 The FSM SHALL have states IDLE and WAIT.
REQ-018 In IDLE, a valid aligned load or store SHALL assert dmem_req combinationally, with dmem_wen = store.
REQ-019 In IDLE, ack in the same cycle SHALL complete the access with zero stall; otherwise the FSM SHALL go to WAIT.
REQ-020 In WAIT, dmem_req and address, data and byte enables SHALL stay asserted and stable; ack SHALL return the FSM to IDLE.
REQ-021 stall_out SHALL = dmem_req & ~dmem_ack.
REQ-022 dmem_ack while dmem_req=0 SHALL be ignored.
REQ-023 wb_d_out SHALL select by wb_ctl: 00 rslt, 01 extracted load data (valid in the ack cycle), 10 imm_ext, 11 zero.
REQ-024 mem_d_out SHALL = wb_d_out; mem_wen_out SHALL = rd_wen_out & ~stall_out; mem_rd_out SHALL = rd_addr.
REQ-025 pc_sel_out SHALL = jmp_ctl | (bch_ctl & rslt[0]); tgt_addr_out SHALL = registered tgt_addr. Both SHALL be gated by ~stall_out.
REQ-026 Latency SHALL be one cycle from EX outputs to WB-side outputs, plus one cycle per non-ack cycle.

Reset
REQ-027 With rst=1 on posedge clk, all internal registers SHALL clear to 0 and the FSM SHALL enter IDLE.
REQ-028 Consequently all outputs SHALL be 0: dmem_req, stall_out, pc_sel_out, rd_wen_out, mem_wen_out and misalign_out.
REQ-029 Reset SHALL take priority over stall.
REQ-030 Reset during WAIT SHALL abandon the request; a later stray ack SHALL be ignored.

Structure
REQ-031 wb_ctl codes, byt_typ codes and the FSM state encodings SHALL live in constants.vh with the existing width macros.
REQ-032 Exactly one sub-module SHALL be used: load_store_align, a purely combinational block computing be, wdata and extracted load data from byt_typ, addr[1:0], rs2 and rdata.

Verification
REQ-033 SW: rslt=0x100, rs2=0xDEADBEEF, ack in the same cycle -> one req, wen=1, be=1111, wdata=0xDEADBEEF, stall_out never 1.
REQ-034 LB: addr=0x103, rdata=0x80FF_FFFF, ack after 3 cycles -> stall_out=1 for 3 cycles, input register held, wb_d_out=0xFFFFFF80, mem_wen_out=1 only in the ack cycle.
REQ-035 LHU: addr=0x102, rdata=0x8001_0000 -> wb_d_out=0x00008001; SB: addr=0x101, rs2=0xAB -> be=0010, wdata=0xABABABAB.
REQ-036 LW: addr=0x102 -> misalign_out=1, dmem_req=0, rd_wen_out=0.
REQ-037 Branch with rslt=1, tgt=0x40 -> pc_sel_out=1, tgt_addr_out=0x40; with rslt=0 -> pc_sel_out=0.
REQ-038 rst asserted in WAIT, then ack one cycle later -> all outputs 0, FSM IDLE, no writeback.
